// File: rtl/knight_link_pkg.sv
// Shared types and constants for the knight-side command link.
package knight_link_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic       {WAIT_HIGH, WAIT_LOW}     asm_state_t;
  typedef enum logic       {TX_IDLE, TX_BUSY}        tx_state_t;

  localparam logic [7:0] ACK = 8'hA5;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, start-edge detect, mid-bit sampling.
// state | meaning
// IDLE  | line idle, watching for a falling edge on rx_s
// START | half-bit wait, then confirm start bit still low
// DATA  | sample 8 data bits LSB first, one per bit period
// STOP  | sample stop bit; 1 -> byte_vld, 0 -> ferr
module uart_rx_byte
  import knight_link_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_vld,
  output logic [7:0] rx_byte,
  output logic       ferr,
  output logic       start_det
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

  logic          sync_q, rx_s_q, rx_prev_q;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitn_q, bitn_d;
  logic [7:0]    shreg_q, shreg_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitn_q    <= '0;
      shreg_q   <= '0;
    end else begin
      sync_q    <= rx;
      rx_s_q    <= sync_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitn_q    <= bitn_d;
      shreg_q   <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitn_d    = bitn_q;
    shreg_d   = shreg_q;
    byte_vld  = 1'b0;
    ferr      = 1'b0;
    start_det = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          start_det = 1'b1;
          state_d   = START;
          cnt_d     = HALF;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          // a high line at mid-start-bit is a glitch, not a frame
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = FULL;
            bitn_d  = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          cnt_d   = FULL;
          if (bitn_q == 3'd7) state_d = STOP;
          else                bitn_d  = bitn_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (rx_s_q) byte_vld = 1'b1;
          else        ferr     = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_byte = shreg_q;

endmodule

// File: rtl/knight_cmd_link.sv
// Knight end of the remote link: two RX bytes -> 16-bit command, response byte -> TX.
// state     | meaning
// WAIT_HIGH | expecting the first (high) command byte
// WAIT_LOW  | high byte held, expecting the low byte
// TX_IDLE   | line idle, waiting for trmt
// TX_BUSY   | shifting start, 8 data, stop bits
module knight_cmd_link
  import knight_link_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

  logic       byte_vld, ferr, start_det;
  logic [7:0] rx_byte;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (RX),
    .byte_vld  (byte_vld),
    .rx_byte   (rx_byte),
    .ferr      (ferr),
    .start_det (start_det)
  );

  asm_state_t    asm_q, asm_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          rdy_q, rdy_d;
  tx_state_t     tx_state_q, tx_state_d;
  logic          tx_q, tx_d, tx_done_q, tx_done_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bitn_q, tx_bitn_d;
  logic [8:0]    tx_shift_q, tx_shift_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q      <= WAIT_HIGH;
      hi_q       <= '0;
      cmd_q      <= '0;
      rdy_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bitn_q  <= '0;
      tx_shift_q <= '0;
    end else begin
      asm_q      <= asm_d;
      hi_q       <= hi_d;
      cmd_q      <= cmd_d;
      rdy_q      <= rdy_d;
      tx_state_q <= tx_state_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bitn_q  <= tx_bitn_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // clear is applied first so a same-cycle set overrides it
  always_comb begin
    asm_d = asm_q;
    hi_d  = hi_q;
    cmd_d = cmd_q;
    rdy_d = rdy_q;
    if (clr_cmd_rdy) rdy_d = 1'b0;
    case (asm_q)
      WAIT_HIGH: begin
        if (start_det) rdy_d = 1'b0;
        if (byte_vld) begin
          hi_d  = rx_byte;
          asm_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (byte_vld) begin
          cmd_d = {hi_q, rx_byte};
          rdy_d = 1'b1;
          asm_d = WAIT_HIGH;
        end else if (ferr) begin
          asm_d = WAIT_HIGH;
        end
      end
      default: asm_d = WAIT_HIGH;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_d       = tx_q;
    tx_done_d  = tx_done_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bitn_d  = tx_bitn_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (trmt) begin
          tx_state_d = TX_BUSY;
          tx_d       = 1'b0;
          tx_shift_d = {1'b1, resp};
          tx_bitn_d  = 4'd9;
          tx_cnt_d   = FULL;
          tx_done_d  = 1'b0;
        end
      end
      TX_BUSY: begin
        if (tx_cnt_q == '0) begin
          if (tx_bitn_q == '0) begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
            tx_done_d  = 1'b1;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[8:1]};
            tx_bitn_d  = tx_bitn_q - 1'b1;
            tx_cnt_d   = FULL;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign TX      = tx_q;
  assign tx_done = tx_done_q;
  assign cmd     = cmd_q;
  assign cmd_rdy = rdy_q;

endmodule

// File: tb/tb_knight_cmd_link.sv
// Directed bench for knight_cmd_link with a frame-level command model and a TX timeline model.
module tb_knight_cmd_link;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        trmt = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, tx_done;
  logic [15:0] cmd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  knight_cmd_link #(.BAUD_DIV(BD)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .trmt        (trmt),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // command model: updated per frame by the stimulus tasks
  logic [15:0] exp_cmd = 16'h0000;
  logic        exp_rdy = 1'b0;
  bit          has_hi = 1'b0;
  logic [7:0]  hi_b = 8'h00;
  bit          rx_dc = 1'b1;
  bit          cmp_en = 1'b0;
  bit          clr_seen = 1'b0;

  // TX model: position m_k within a 10*BD clock frame
  bit          m_busy = 1'b0;
  bit          was_busy;
  int          m_k = 0;
  logic [9:0]  m_frame = 10'h3FF;
  logic        m_done = 1'b0;
  logic        exp_tx;

  always @(posedge clk) begin
    was_busy = m_busy;
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      if (m_busy) begin
        m_k++;
        if (m_k == 10 * BD) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
      if (!was_busy && trmt) begin
        m_busy  = 1'b1;
        m_k     = 0;
        m_frame = {1'b1, resp, 1'b0};
        m_done  = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      exp_tx = m_busy ? m_frame[m_k / BD] : 1'b1;
      check("tx_line", {15'd0, TX}, {15'd0, exp_tx});
      check("tx_done", {15'd0, tx_done}, {15'd0, m_done});
      if (!rx_dc) begin
        check("cmd", cmd, exp_cmd);
        check("cmd_rdy", {15'd0, cmd_rdy}, {15'd0, exp_rdy});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_dc = 1'b1;
    if (!has_hi) exp_rdy = 1'b0;
    RX = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(BD);
    end
    RX = stop;
    tick(BD);
    RX = 1'b1;
    if (!stop) begin
      has_hi = 1'b0;
    end else if (!has_hi) begin
      hi_b   = b;
      has_hi = 1'b1;
    end else begin
      exp_cmd = {hi_b, b};
      exp_rdy = 1'b1;
      has_hi  = 1'b0;
    end
    rx_dc = 1'b0;
  endtask

  task automatic send_trmt(input logic [7:0] b);
    resp = b;
    trmt = 1'b1;
    tick(1);
    trmt = 1'b0;
  endtask

  task automatic model_reset();
    exp_cmd = 16'h0000;
    exp_rdy = 1'b0;
    has_hi  = 1'b0;
  endtask

  logic [9:0] ack_seq = 10'b1101001010;
  logic [7:0] partial_b;

  initial begin
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    rx_dc  = 1'b0;
    tick(2);
    check("rst_tx", {15'd0, TX}, 16'd1);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
    check("rst_tx_done", {15'd0, tx_done}, 16'd0);
    rst = 1'b0;
    tick(4);

    // basic command and clear
    send_byte(8'h40, 1'b1);
    tick(8);
    send_byte(8'h01, 1'b1);
    check("cmd_4001", cmd, 16'h4001);
    check("rdy_4001", {15'd0, cmd_rdy}, 16'd1);
    tick(5);
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
    check("clr_rdy", {15'd0, cmd_rdy}, 16'd0);
    check("clr_cmd_hold", cmd, 16'h4001);
    tick(10);

    // ACK transmit with ignored mid-frame trmt, then back-to-back accept
    send_trmt(knight_link_pkg::ACK);
    check("tx_start_bit", {15'd0, TX}, 16'd0);
    for (int c = 1; c <= 165; c++) begin
      tick(1);
      if (c == 49) begin
        trmt = 1'b1;
        resp = 8'h00;
      end
      if (c == 50) trmt = 1'b0;
      if (c == 160) begin
        trmt = 1'b1;
        resp = 8'h5A;
      end
      if (c == 161) trmt = 1'b0;
      if (c % BD == BD / 2 && c < 10 * BD)
        check("tx_ack_bit", {15'd0, TX}, {15'd0, ack_seq[c / BD]});
      if (c == 159) check("tx_done_early", {15'd0, tx_done}, 16'd0);
      if (c == 160) check("tx_done_160", {15'd0, tx_done}, 16'd1);
    end
    tick(170);

    // framing error drops the first byte
    send_byte(8'h12, 1'b0);
    tick(8);
    send_byte(8'h34, 1'b1);
    tick(8);
    send_byte(8'h56, 1'b1);
    check("cmd_3456", cmd, 16'h3456);
    check("rdy_3456", {15'd0, cmd_rdy}, 16'd1);
    tick(10);

    // short glitch: clears stale ready, produces no byte
    rx_dc = 1'b1;
    if (!has_hi) exp_rdy = 1'b0;
    RX = 1'b0;
    tick(4);
    RX = 1'b1;
    tick(24);
    rx_dc = 1'b0;
    check("glitch_rdy", {15'd0, cmd_rdy}, 16'd0);
    check("glitch_cmd", cmd, 16'h3456);
    send_byte(8'h7E, 1'b1);
    tick(8);
    send_byte(8'h81, 1'b1);
    check("cmd_7e81", cmd, 16'h7E81);
    tick(10);

    // reset in the middle of the second byte, TX also mid-frame
    send_byte(8'hBE, 1'b1);
    tick(8);
    send_trmt(8'h3C);
    rx_dc = 1'b1;
    partial_b = 8'hEF;
    RX = 1'b0;
    tick(BD);
    for (int i = 0; i < 4; i++) begin
      RX = partial_b[i];
      tick(BD);
    end
    RX  = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    check("mid_rst_cmd", cmd, 16'h0000);
    check("mid_rst_rdy", {15'd0, cmd_rdy}, 16'd0);
    check("mid_rst_tx", {15'd0, TX}, 16'd1);
    rx_dc = 1'b0;
    tick(8);
    send_byte(8'h22, 1'b1);
    tick(8);
    send_byte(8'h02, 1'b1);
    check("cmd_2202", cmd, 16'h2202);
    tick(10);

    // full duplex with clear coinciding with the set cycle
    fork
      begin
        tick(3);
        send_trmt(knight_link_pkg::ACK);
      end
      begin
        send_byte(8'h60, 1'b1);
        tick(8);
        fork
          send_byte(8'h10, 1'b1);
          begin
            clr_cmd_rdy = 1'b1;
            clr_seen = 1'b0;
            for (int i = 0; i < 400 && !clr_seen; i++) begin
              @(negedge clk);
              if (cmd_rdy === 1'b1) clr_seen = 1'b1;
            end
            clr_cmd_rdy = 1'b0;
            check("set_beats_clr", {15'd0, clr_seen}, 16'd1);
          end
        join
      end
    join
    check("cmd_6010", cmd, 16'h6010);
    check("rdy_6010", {15'd0, cmd_rdy}, 16'd1);
    tick(200);
    check("duplex_tx_done", {15'd0, tx_done}, 16'd1);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/knight_cmd_link.md
# knight_cmd_link

Knight-side end of the remote command link. Deserializes the two-byte UART stream sent by the remote controller (high byte first) into one 16-bit command for the command processor, and serializes the 8-bit response/acknowledge byte (positive ack 8'hA5) back to the remote. It sits between the top-level RX/TX pins and the command processor, opposite the remote's command transmitter.

## Interface
Parameters:
- BAUD_DIV, 2604, clocks per bit period (≥ 8); the same value is used for RX and TX.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- RX  in  1  serial data from remote, asynchronous, idle high
- TX  out  1  serial data to remote, idle high
- cmd  out  16  assembled command, {first byte, second byte}
- cmd_rdy  out  1  level; a complete command is valid on cmd
- clr_cmd_rdy  in  1  consumer acknowledges cmd; clears cmd_rdy
- resp  in  8  response byte to transmit
- trmt  in  1  one-cycle request to transmit resp
- tx_done  out  1  level; last transmission finished

## Operation
- Reset values: TX=1, cmd=0, cmd_rdy=0, tx_done=0. RX synchronizer flops reset to 1. All FSMs go to IDLE and assembly goes to WAIT_HIGH.
- RX synchronization: RX passes through 2 flops, and all RX logic uses the synchronized value rx_s.
- RX byte FSM states:
  - IDLE: a falling edge of rx_s moves the FSM to START and loads the baud counter with BAUD_DIV/2.
  - START: when the counter expires, sample rx_s. If the sample is 1, this is a false start; return to IDLE with no byte. If 0, go to DATA and reload the counter with BAUD_DIV.
  - DATA: sample 8 bits LSB first, one per BAUD_DIV, then go to STOP.
  - STOP: sample rx_s. If 1, emit byte_vld for one cycle. If 0, this is a framing error; the byte is discarded and ferr pulses. Return to IDLE in both cases.
- Assembly FSM states:
  - WAIT_HIGH: a byte_vld byte goes into hi_byte and the FSM moves to WAIT_LOW. The falling start edge detected in this state clears cmd_rdy, so a new command invalidates the stale one.
  - WAIT_LOW: on byte_vld, set cmd={hi_byte, byte}, set cmd_rdy, and return to WAIT_HIGH.
  - ferr in either state returns the FSM to WAIT_HIGH and drops the partial command.
- cmd holds its value until the next completed command.
- cmd_rdy priority: if set and clr_cmd_rdy occur in the same cycle, set wins.
- TX FSM states:
  - IDLE: trmt latches resp, clears tx_done, and moves to BUSY.
  - BUSY: shift the frame {1, resp, 0} LSB first, i.e. start bit, then 8 data bits, then stop bit. Each bit lasts BAUD_DIV clocks. After the 10th bit, set tx_done and return to IDLE.
  - trmt while BUSY is ignored, with no queuing.
- RX and TX run fully independently, so full-duplex operation is legal.
- rst mid-frame aborts both directions on the next edge. TX returns high immediately and any partial command is discarded.

## Timing
- RX: byte_vld fires 2 (synchronizer) + 1 (edge detect) + BAUD_DIV/2 + 9·BAUD_DIV clocks after the RX falling edge, within ±1 clock. cmd/cmd_rdy update on the cycle after the second byte's byte_vld.
- TX: TX goes low the cycle after trmt. The frame lasts exactly 10·BAUD_DIV clocks. tx_done rises on the cycle TX returns to idle after the stop bit.
- A new trmt is accepted on the cycle tx_done rises.

## Structure
- Package knight_link_pkg holds:
  - typedefs rx_state_t {IDLE, START, DATA, STOP}, asm_state_t {WAIT_HIGH, WAIT_LOW}, tx_state_t {TX_IDLE, TX_BUSY};
  - constant ACK = 8'hA5.
- Sub-module uart_rx_byte contains the synchronizer, baud counter and rx FSM, with outputs byte_vld, rx_byte[7:0], ferr, start_det. knight_cmd_link instantiates it and adds the assembly FSM and the TX path inline.

## Test plan
Run all scenarios with BAUD_DIV=16.
- Send bytes 8'h40 then 8'h01 on RX → cmd=16'h4001 and cmd_rdy=1 one cycle after the second stop sample. Pulse clr_cmd_rdy → cmd_rdy=0 on the next cycle, and cmd stays 16'h4001.
- trmt with resp=8'hA5 → TX bit sequence 0,1,0,1,0,0,1,0,1,1, 16 clocks each. tx_done rises at clock 160 after trmt. A second trmt at clock 50 is ignored.
- Send 8'h12 with stop bit 0, then 8'h34, 8'h56 → the first byte is dropped and cmd=16'h3456.
- 4-clock low glitch on RX while idle → no byte_vld, and the assembly state stays WAIT_HIGH.
- Assert rst mid-way through the second byte of 16'hBEEF → cmd=0 and cmd_rdy=0. A subsequent 16'h2202 is received correctly.
- Full duplex: receive 16'h6010 while transmitting 8'hA5 → both complete with correct data and timing. clr_cmd_rdy coinciding with the set cycle leaves cmd_rdy=1.
